// File: rtl/multiport_ram_param.sv
// multiport_ram_param: N-port synchronous RAM with lowest-port-wins write
// arbitration, per-port conflict flags and a hardware clear engine.
module multiport_ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NPORTS   = 4,
  parameter int RDW_MODE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_req,
  input  logic [NPORTS*ADDR_W-1:0]   addr,
  input  logic [NPORTS*DATA_W-1:0]   data_in,
  input  logic [NPORTS-1:0]          we,
  output logic [NPORTS*DATA_W-1:0]   data_out,
  output logic [NPORTS-1:0]          conflict,
  output logic                       busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   clr_ptr;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic [ADDR_W-1:0]   pa  [NPORTS];
  logic [DATA_W-1:0]   pd  [NPORTS];
  logic [DATA_W-1:0]   rd  [NPORTS];
  logic [NPORTS-1:0]   win;
  logic [NPORTS-1:0]   lose;

  // Split the flat port buses into per-port fields
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      pa[p] = addr[p*ADDR_W +: ADDR_W];
      pd[p] = data_in[p*DATA_W +: DATA_W];
    end
  end

  // A write survives only if no lower-index port writes the same address
  always_comb begin
    win = we;
    for (int p = 1; p < NPORTS; p++) begin
      for (int q = 0; q < p; q++) begin
        if (we[q] && we[p] && pa[q] == pa[p]) win[p] = 1'b0;
      end
    end
    lose = we & ~win;
  end

  // Read path: array word, optionally bypassed by the winning write data
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rd[p] = ram[pa[p]];
      if (RDW_MODE == 0) begin
        for (int q = NPORTS-1; q >= 0; q--) begin
          if (win[q] && pa[q] == pa[p]) rd[p] = pd[q];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nx;
  end

  // Next-state: clear sweeps once to the last word, idle waits for clr_req
  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_ptr == '1) state_nx = IDLE;
      IDLE:  if (clr_req)       state_nx = CLEAR;
      default: state_nx = CLEAR;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == CLEAR);
  end

  // Clear pointer restarts on reset or on an accepted clear request
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && clr_req)) clr_ptr <= '0;
    else if (state == CLEAR)              clr_ptr <= clr_ptr + ADDR_W'(1);
  end

  // Registered read data and conflict flags, forced to zero while clearing
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      data_out <= '0;
      conflict <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        data_out[p*DATA_W +: DATA_W] <= rd[p];
      end
      conflict <= lose;
    end
  end

  // Array writes: clear engine or surviving port writes, none during reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        ram[clr_ptr] <= '0;
      end else begin
        for (int p = 0; p < NPORTS; p++) begin
          if (win[p]) ram[pa[p]] <= pd[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_ram_param.sv
// tb_multiport_ram_param: drives a write-first and a read-first instance
// with identical stimulus and checks both against expected tables.
module tb_multiport_ram_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic [15:0] addr;
  logic [31:0] din;
  logic [3:0]  we;
  logic [31:0] dout0, dout1;
  logic [3:0]  cf0, cf1;
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiport_ram_param #(.RDW_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .addr(addr),
    .data_in(din), .we(we), .data_out(dout0),
    .conflict(cf0), .busy(busy0)
  );

  multiport_ram_param #(.RDW_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .addr(addr),
    .data_in(din), .we(we), .data_out(dout1),
    .conflict(cf1), .busy(busy1)
  );

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    logic [31:0] q0;
    logic [31:0] q1;
    logic [3:0]  cf;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] q0;
    logic [31:0] q1;
    logic [3:0]  cf;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    addr = v.addr;
    din  = v.din;
    we   = v.we;
    e.name = v.name;
    e.q0 = v.q0;
    e.q1 = v.q1;
    e.cf = v.cf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    we  = '0;
    din = '0;
    e = sb.pop_front();
    chk({e.name, " dout wf"}, dout0, e.q0);
    chk({e.name, " dout rf"}, dout1, e.q1);
    chk({e.name, " conflict wf"}, {28'd0, cf0}, {28'd0, e.cf});
    chk({e.name, " conflict rf"}, {28'd0, cf1}, {28'd0, e.cf});
    chk({e.name, " busy"}, {31'd0, busy0 | busy1}, 32'd0);
  endtask

  task automatic read_all_zero(input string name);
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.name = name;
      v.addr = {4'(4*i+3), 4'(4*i+2), 4'(4*i+1), 4'(4*i)};
      v.din  = '0;
      v.we   = '0;
      v.q0   = '0;
      v.q1   = '0;
      v.cf   = '0;
      step(v);
    end
  endtask

  task automatic busy_run(input string name, input bit chk_out,
                          input bit inject);
    int n = 0;
    while (busy0 && n < 100) begin
      n++;
      if (chk_out) begin
        chk({name, " clr dout wf"}, dout0, 32'd0);
        chk({name, " clr dout rf"}, dout1, 32'd0);
        chk({name, " clr conflict"}, {24'd0, cf0, cf1}, 32'd0);
      end
      if (inject && n == 5) clr_req = 1'b1;
      if (inject && n == 10) begin
        we   = 4'b0001;
        addr = 16'h0003;
        din  = 32'h0000_0055;
      end
      @(posedge clk);
      #1;
      clr_req = 1'b0;
      we      = '0;
      din     = '0;
      addr    = '0;
    end
    chk({name, " busy cycles"}, 32'(n), 32'd16);
    chk({name, " busy rf"}, {31'd0, busy1}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"par wr",   16'h4321, 32'h44332211, 4'hF,
                 32'h44332211, 32'h00000000, 4'h0};
    vecs[1]  = '{"par rd",   16'h4321, 32'h0, 4'h0,
                 32'h44332211, 32'h44332211, 4'h0};
    vecs[2]  = '{"coll 1v3", 16'h7777, 32'hBB00AA00, 4'b1010,
                 32'hAAAAAAAA, 32'h00000000, 4'b1000};
    vecs[3]  = '{"coll rd",  16'h7777, 32'h0, 4'h0,
                 32'hAAAAAAAA, 32'hAAAAAAAA, 4'h0};
    vecs[4]  = '{"seed 5",   16'h0050, 32'h00001000, 4'b0010,
                 32'h00001000, 32'h00000000, 4'h0};
    vecs[5]  = '{"rdw",      16'h1515, 32'h00000020, 4'b0001,
                 32'h11201120, 32'h11101110, 4'h0};
    vecs[6]  = '{"rdw rd",   16'h5555, 32'h0, 4'h0,
                 32'h20202020, 32'h20202020, 4'h0};
    vecs[7]  = '{"coll all", 16'h9999, 32'h04030201, 4'hF,
                 32'h01010101, 32'h00000000, 4'b1110};
    vecs[8]  = '{"call rd",  16'h9999, 32'h0, 4'h0,
                 32'h01010101, 32'h01010101, 4'h0};
    vecs[9]  = '{"coll 2x2", 16'hBABA, 32'hD3C2D1C0, 4'hF,
                 32'hD1C0D1C0, 32'h00000000, 4'b1100};
    vecs[10] = '{"c2x2 rd",  16'hABAB, 32'h0, 4'h0,
                 32'hC0D1C0D1, 32'hC0D1C0D1, 4'h0};
    vecs[11] = '{"fill 0",   16'h3210, 32'hFFFFFFFF, 4'hF,
                 32'hFFFFFFFF, 32'h33221100, 4'h0};
    vecs[12] = '{"fill 1",   16'h7654, 32'hFFFFFFFF, 4'hF,
                 32'hFFFFFFFF, 32'hAA002044, 4'h0};
    vecs[13] = '{"fill 2",   16'hBA98, 32'hFFFFFFFF, 4'hF,
                 32'hFFFFFFFF, 32'hD1C00100, 4'h0};
    vecs[14] = '{"fill 3",   16'hFEDC, 32'hFFFFFFFF, 4'hF,
                 32'hFFFFFFFF, 32'h00000000, 4'h0};

    rst = 1'b1;
    clr_req = 1'b0;
    addr = '0;
    din = '0;
    we = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst dout", dout0 | dout1, 32'd0);
    chk("rst conflict", {24'd0, cf0, cf1}, 32'd0);
    chk("rst busy", {30'd0, busy0, busy1}, 32'd3);
    rst = 1'b0;
    busy_run("reset", 1'b1, 1'b0);
    read_all_zero("post rst");

    for (int i = 0; i < 15; i++) step(vecs[i]);

    clr_req = 1'b1;
    addr = '0;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    chk("clr_req cycle read", dout0 & dout1, 32'hFFFFFFFF);
    chk("clr_req busy", {30'd0, busy0, busy1}, 32'd3);
    busy_run("clr_req", 1'b0, 1'b1);
    read_all_zero("post clr");

    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_run("mid rst", 1'b1, 1'b0);
    read_all_zero("post mid rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_ram_param.md
# multiport_ram_param

Parametrised N-port synchronous RAM, successor to the fixed 4-port 16x8 multiport RAM. It adds configurable width, depth and port count, deterministic write-collision arbitration with per-port conflict flags, and a selectable read-during-write mode. It also has a hardware clear engine that zeroes the whole array after reset or on request. It sits as shared scratch storage between several same-clock requesters.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- NPORTS, 4, number of read/write ports (>=1)
- RDW_MODE, 0, read-during-write: 0 = write-first (new data), 1 = read-first (old data)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr_req  in  1  pulse: start a full-array clear (ignored while busy)
- addr  in  NPORTS*ADDR_W  port p address at [p*ADDR_W +: ADDR_W]
- data_in  in  NPORTS*DATA_W  port p write data at [p*DATA_W +: DATA_W]
- we  in  NPORTS  per-port write enable
- data_out  out  NPORTS*DATA_W  registered read data, port p at [p*DATA_W +: DATA_W]
- conflict  out  NPORTS  registered: bit p = port p's write was dropped this access
- busy  out  1  clear engine active; port accesses ignored

## Operation
- FSM states: CLEAR, IDLE.
- rst=1: state<=CLEAR, clr_ptr<=0, data_out<=0, conflict<=0, busy<=1. Array contents untouched until rst released.
- CLEAR:
  - each cycle writes 0 to ram[clr_ptr], clr_ptr++.
  - after clr_ptr==DEPTH-1 is written, go to IDLE. Total DEPTH cycles after rst deasserts.
  - we/addr/data_in ignored. data_out and conflict held at 0. busy=1.
- IDLE: busy=0. clr_req=1 -> CLEAR with clr_ptr<=0 (takes effect next cycle). Port accesses in the clr_req cycle are still serviced normally.
- Writes (IDLE): all ports with we=1 write in the same cycle.
  - Collision (two or more writing ports share an address): lowest-index port wins. Every losing port gets conflict[p]=1 for one cycle; its write is discarded.
  - Distinct addresses never conflict.
- Reads (IDLE): every port reads ram[addr_p] each cycle, whether or not it writes.
  - RDW_MODE=0: if any port writes addr_p this cycle, data_out_p = winning write data. This covers the writer itself, collision losers and pure readers.
  - RDW_MODE=1: data_out_p = array contents before this cycle's writes.
- conflict bits not set by a collision return to 0 the next IDLE cycle.
- Width rule: no arithmetic on data. clr_ptr is ADDR_W bits; terminal detect at all-ones, no wrap into a second pass.

## Timing
- Read latency 1 cycle: address sampled at edge k, data_out valid after edge k; held until the next edge.
- Write visible to a read issued on the following cycle (in both modes).
- conflict aligned with data_out (same edge as the colliding access).
- Clear: DEPTH cycles. First IDLE access is allowed on the cycle busy is first sampled 0.
- rst mid-CLEAR or mid-operation: restarts clear from address 0 on release. No partial-write guarantees for the reset cycle.
- clr_req while busy=1: ignored, not queued.

## Test plan
- Reset/clear: NPORTS=4, ADDR_W=4. Pulse rst 2 cycles -> busy=1 for exactly 16 cycles after release, then 0. Read all 16 addresses -> data_out=0x00, conflict=0.
- Parallel writes: ports 0..3 write 0x11,0x22,0x33,0x44 to addr 1,2,3,4 in one cycle; next cycle all read those addresses -> 0x11,0x22,0x33,0x44, conflict=0.
- Collision: ports 1 and 3 write 0xAA/0xBB to addr 7 -> conflict=4'b1000. Following read of addr 7 on any port -> 0xAA.
- Read-during-write: ram[5]=0x10. Port 0 writes 0x20 to addr 5 while port 2 reads addr 5 -> RDW_MODE=0: both outputs 0x20. RDW_MODE=1: port 2 gets 0x10, port 0 gets 0x10. Next cycle read -> 0x20.
- clr_req: fill addr 0..15 with 0xFF, pulse clr_req -> busy 16 cycles. A write (port 0, addr 3, 0x55) during busy is ignored. Afterwards all reads = 0x00. A second clr_req during busy does not extend busy.
- Reset mid-clear: assert rst at clear cycle 6 -> on release, busy lasts a full 16 cycles. Outputs are 0 throughout.
